// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_e;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// WAIT-state watchdog: counts enabled cycles, flags the last allowed one.
module mem_port_arbiter_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data-memory ports onto one single-ported bus,
// one registered transaction at a time, with stale-fetch discard on flush.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              flush_if_i,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              stall_if_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [1:0]        dm_size_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_valid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              stall_mem_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [1:0]        bus_size_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              bus_err_o
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e        state_q;
    arb_owner_e        owner_q;
    mem_req_t          req_q;
    logic              bus_req_q;
    logic              discard_q;
    logic [SW-1:0]     starve_q;
    logic              if_vld_q;
    logic              dm_vld_q;
    logic              err_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic              if_cand;
    logic              starved;
    logic              win_if;
    logic              win_dm;
    logic              own_if;
    logic              tmo_clr;
    logic              tmo_en;
    logic              expire;
    logic [DATA_W-1:0] resp_data;

    // A flushed fetch is not a candidate, so data may win that cycle.
    assign if_cand   = if_req_i & ~flush_if_i;
    assign starved   = (starve_q == STARVE_MAX);
    assign win_if    = if_cand & (~dm_req_i | starved);
    assign win_dm    = dm_req_i & ~win_if;
    assign own_if    = (owner_q == OWN_IF);
    assign tmo_clr   = (state_q == ADDR) & bus_gnt_i;
    assign tmo_en    = (state_q == WAIT);
    assign resp_data = bus_rvalid_i ? bus_rdata_i : '0;

    mem_port_arbiter_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expire_o (expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            req_q      <= '0;
            bus_req_q  <= 1'b0;
            discard_q  <= 1'b0;
            starve_q   <= '0;
            if_vld_q   <= 1'b0;
            dm_vld_q   <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_vld_q <= 1'b0;
            dm_vld_q <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!if_req_i) begin
                        starve_q <= '0;
                    end
                    if (win_if) begin
                        owner_q   <= OWN_IF;
                        req_q     <= '{we: 1'b0, size: SIZE_WORD,
                                       addr: if_addr_i, wdata: '0};
                        bus_req_q <= 1'b1;
                        starve_q  <= '0;
                        state_q   <= ADDR;
                    end else if (win_dm) begin
                        owner_q   <= OWN_DM;
                        req_q     <= '{we: dm_we_i, size: dm_size_i,
                                       addr: dm_addr_i, wdata: dm_wdata_i};
                        bus_req_q <= 1'b1;
                        if (if_req_i && !starved) begin
                            starve_q <= starve_q + SW'(1);
                        end
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (flush_if_i && own_if && !bus_gnt_i) begin
                        bus_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (bus_gnt_i) begin
                        bus_req_q <= 1'b0;
                        state_q   <= WAIT;
                        if (flush_if_i && own_if) begin
                            discard_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (flush_if_i && own_if) begin
                        discard_q <= 1'b1;
                    end
                    if (bus_rvalid_i || expire) begin
                        state_q <= RESP;
                        err_q   <= ~bus_rvalid_i;
                        if (own_if) begin
                            if_rdata_q <= resp_data;
                            if_vld_q   <= if_req_i & ~discard_q & ~flush_if_i;
                        end else begin
                            dm_rdata_q <= resp_data;
                            dm_vld_q   <= dm_req_i;
                        end
                    end
                end
                RESP: begin
                    discard_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // A flush landing on the response cycle still kills the stale fetch.
    assign if_valid_o  = if_vld_q & ~flush_if_i;
    assign if_rdata_o  = if_rdata_q;
    assign dm_valid_o  = dm_vld_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign stall_if_o  = if_req_i & ~if_valid_o;
    assign stall_mem_o = dm_req_i & ~dm_valid_o;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = req_q.we;
    assign bus_size_o  = req_q.size;
    assign bus_addr_o  = req_q.addr;
    assign bus_wdata_o = req_q.wdata;
    assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small bus responder.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        flush = 1'b0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        stall_if;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [1:0]  dm_size = 2'b10;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        stall_mem;
    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b1;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err;

    int          checks = 0;
    int          failures = 0;
    int          rv_delay = 1;
    logic        rv_en = 1'b1;
    int          rv_cnt = 0;
    logic [31:0] rv_data = '0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .flush_if_i   (flush),
        .if_valid_o   (if_valid),
        .if_rdata_o   (if_rdata),
        .stall_if_o   (stall_if),
        .dm_req_i     (dm_req),
        .dm_we_i      (dm_we),
        .dm_size_i    (dm_size),
        .dm_addr_i    (dm_addr),
        .dm_wdata_i   (dm_wdata),
        .dm_valid_o   (dm_valid),
        .dm_rdata_o   (dm_rdata),
        .stall_mem_o  (stall_mem),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_size_o   (bus_size),
        .bus_addr_o   (bus_addr),
        .bus_wdata_o  (bus_wdata),
        .bus_gnt_i    (bus_gnt),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .bus_err_o    (bus_err)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h10) ? 32'h13 : (a | 32'h1000_0000);
    endfunction

    // Responder: rvalid rv_delay cycles after an accepted request.
    initial begin : bus_model
        forever begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rv_data;
                end
            end
            if (rv_en && bus_req && bus_gnt) begin
                rv_cnt  = rv_delay;
                rv_data = bus_we ? 32'h0 : mem_f(bus_addr);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({bus_req, if_valid, dm_valid, bus_err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {bus_req, if_valid, dm_valid, bus_err});
        end
        checks++;
        if ({if_rdata, dm_rdata, bus_addr, bus_wdata} !== 128'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0",
                     {if_rdata, dm_rdata, bus_addr, bus_wdata});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        if_addr = 32'h10;
        if_req  = 1'b1;
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            failures++;
            $display("FAIL fetch_stall_c0 got=%b exp=1", stall_if);
        end
        step();
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h10 || bus_we !== 1'b0) begin
            failures++;
            $display("FAIL fetch_addr_phase got=%b/%h/%b exp=1/00000010/0",
                     bus_req, bus_addr, bus_we);
        end
        checks++;
        if (stall_if !== 1'b1) begin
            failures++;
            $display("FAIL fetch_stall_c1 got=%b exp=1", stall_if);
        end
        step();
        checks++;
        if (stall_if !== 1'b1 || if_valid !== 1'b0 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_wait got=%b/%b/%b exp=1/0/0",
                     stall_if, if_valid, bus_req);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h13) begin
            failures++;
            $display("FAIL fetch_resp got=%b/%h exp=1/00000013",
                     if_valid, if_rdata);
        end
        checks++;
        if (stall_if !== 1'b0) begin
            failures++;
            $display("FAIL fetch_stall_c3 got=%b exp=0", stall_if);
        end
        if_req = 1'b0;
        step();
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_pulse got=%b exp=0", if_valid);
        end
    endtask

    task automatic test_priority();
        int dm_first;
        int if_first;
        int stall_bad;
        dm_first  = -1;
        if_first  = -1;
        stall_bad = 0;
        if_addr = 32'h20;
        if_req  = 1'b1;
        dm_we   = 1'b0;
        dm_size = 2'b10;
        dm_addr = 32'h100;
        dm_req  = 1'b1;
        #1;
        for (int c = 0; c < 16; c++) begin
            if (c == 1) begin
                checks++;
                if (bus_addr !== 32'h100) begin
                    failures++;
                    $display("FAIL prio_winner got=%h exp=00000100", bus_addr);
                end
            end
            if (dm_valid === 1'b1 && dm_first < 0) begin
                dm_first = c;
                checks++;
                if (stall_mem !== 1'b0) begin
                    failures++;
                    $display("FAIL prio_stall_mem got=%b exp=0", stall_mem);
                end
                dm_req = 1'b0;
            end
            if (if_valid === 1'b1) begin
                if_first = c;
                if_req = 1'b0;
                break;
            end
            if (stall_if !== 1'b1) stall_bad++;
            step();
        end
        step();
        checks++;
        if (dm_first !== 3 || if_first !== 7) begin
            failures++;
            $display("FAIL prio_order got=dm@%0d if@%0d exp=dm@3 if@7",
                     dm_first, if_first);
        end
        checks++;
        if (stall_bad !== 0) begin
            failures++;
            $display("FAIL prio_stall_if got=%0d gaps exp=0", stall_bad);
        end
        checks++;
        if (dm_rdata !== 32'h1000_0100 || if_rdata !== 32'h1000_0020) begin
            failures++;
            $display("FAIL prio_rdata got=%h/%h exp=10000100/10000020",
                     dm_rdata, if_rdata);
        end
    endtask

    task automatic test_store();
        dm_we    = 1'b1;
        dm_size  = 2'b10;
        dm_addr  = 32'h200;
        dm_wdata = 32'hDEAD_BEEF;
        dm_req   = 1'b1;
        #1;
        checks++;
        if (stall_mem !== 1'b1) begin
            failures++;
            $display("FAIL store_stall got=%b exp=1", stall_mem);
        end
        step();
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_size !== 2'b10 ||
            bus_addr !== 32'h200 || bus_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store_fields got=%b/%b/%b/%h/%h exp=1/1/10/00000200/deadbeef",
                     bus_req, bus_we, bus_size, bus_addr, bus_wdata);
        end
        step();
        step();
        checks++;
        if (dm_valid !== 1'b1 || stall_mem !== 1'b0) begin
            failures++;
            $display("FAIL store_resp got=%b/%b exp=1/0", dm_valid, stall_mem);
        end
        dm_req = 1'b0;
        dm_we  = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int runs[2];
        int run;
        int dm_cnt;
        run    = 0;
        dm_cnt = 0;
        runs[0] = -1;
        runs[1] = -1;
        if_addr = 32'h30;
        if_req  = 1'b1;
        dm_addr = 32'h100;
        dm_req  = 1'b1;
        #1;
        for (int c = 0; c < 120 && run < 2; c++) begin
            if (dm_valid === 1'b1) begin
                dm_cnt++;
                dm_addr = dm_addr + 32'h4;
            end
            if (if_valid === 1'b1) begin
                runs[run] = dm_cnt;
                dm_cnt = 0;
                run++;
            end
            if (run < 2) step();
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        checks++;
        if (runs[0] !== 4) begin
            failures++;
            $display("FAIL starve_first got=%0d exp=4", runs[0]);
        end
        checks++;
        if (runs[1] !== 4) begin
            failures++;
            $display("FAIL starve_rearm got=%0d exp=4", runs[1]);
        end
    endtask

    task automatic test_flush();
        int first;
        first    = -1;
        rv_delay = 3;
        if_addr  = 32'h40;
        if_req   = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (c == 2) flush = 1'b1;
            if (c == 3) begin
                flush    = 1'b0;
                if_addr  = 32'h44;
                rv_delay = 1;
            end
            if (c == 7) begin
                checks++;
                if (bus_req !== 1'b1 || bus_addr !== 32'h44) begin
                    failures++;
                    $display("FAIL flush_refetch got=%b/%h exp=1/00000044",
                             bus_req, bus_addr);
                end
            end
            if (if_valid === 1'b1) begin
                first = c;
                break;
            end
            step();
        end
        checks++;
        if (first !== 9 || if_rdata !== 32'h1000_0044) begin
            failures++;
            $display("FAIL flush_discard got=valid@%0d/%h exp=valid@9/10000044",
                     first, if_rdata);
        end
        if_req = 1'b0;
        step();
        bus_gnt = 1'b0;
        if_addr = 32'h50;
        if_req  = 1'b1;
        step();
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL withdraw_addr got=%b exp=1", bus_req);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (bus_req !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_drop got=%b exp=0", bus_req);
        end
        bus_gnt = 1'b1;
        first = -1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (if_valid === 1'b1) begin
                first = c;
                break;
            end
        end
        checks++;
        if (first < 0 || if_rdata !== 32'h1000_0050) begin
            failures++;
            $display("FAIL withdraw_retry got=valid@%0d/%h exp=valid/10000050",
                     first, if_rdata);
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_timeout_reset();
        int first;
        logic err_after;
        first     = -1;
        err_after = 1'bx;
        rv_en   = 1'b0;
        dm_we   = 1'b0;
        dm_addr = 32'h300;
        dm_req  = 1'b1;
        #1;
        for (int c = 0; c < 100; c++) begin
            if (bus_err === 1'b1) begin
                first = c;
                checks++;
                if (dm_valid !== 1'b1 || dm_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL timeout_resp got=%b/%h exp=1/00000000",
                             dm_valid, dm_rdata);
                end
                dm_req = 1'b0;
                step();
                err_after = bus_err;
                break;
            end
            step();
        end
        checks++;
        if (first !== 66) begin
            failures++;
            $display("FAIL timeout_cycle got=%0d exp=66", first);
        end
        checks++;
        if (err_after !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse got=%b exp=0", err_after);
        end
        rv_en   = 1'b1;
        bus_gnt = 1'b0;
        dm_addr = 32'h304;
        dm_req  = 1'b1;
        step();
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_addr_pre got=%b exp=1", bus_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus_req !== 1'b0 || bus_addr !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_addr got=%b/%h exp=0/00000000",
                     bus_req, bus_addr);
        end
        step();
        dm_req  = 1'b0;
        bus_gnt = 1'b1;
        rst     = 1'b0;
        step();
    endtask

    initial begin : main
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_back_to_back();
        test_flush();
        test_timeout_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between the 5-stage pipeline's instruction-fetch port and its data-memory port.
- Runs one bus transaction at a time through a registered request/grant/response FSM.
- Drives stall requests back to the hazard logic while a port waits.
- Discards fetch responses made stale by a taken branch or jump (pc_src_ex) flush.

Parameters:
- ADDR_W, 32, address width of all ports and the bus.
- DATA_W, 32, read/write data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced.
- TIMEOUT, 64, WAIT-state cycles before a transaction is abandoned with an error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- if_req_i  in  1  fetch request; held stable until if_valid_o.
- if_addr_i  in  ADDR_W  fetch address.
- flush_if_i  in  1  pc_src_ex; cancels the in-flight or pending fetch.
- if_valid_o  out  1  fetch response pulse.
- if_rdata_o  out  DATA_W  fetched instruction.
- stall_if_o  out  1  fetch stage must hold.
- dm_req_i  in  1  data request; held stable until dm_valid_o.
- dm_we_i  in  1  1 = store.
- dm_size_i  in  2  byte/half/word, passed through.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  store data.
- dm_valid_o  out  1  data response pulse.
- dm_rdata_o  out  DATA_W  load data, raw, unextended.
- stall_mem_o  out  1  memory stage must hold.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write enable.
- bus_size_o  out  2  bus access size.
- bus_addr_o  out  ADDR_W  bus address.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_gnt_i  in  1  bus accepted the request this cycle.
- bus_rvalid_i  in  1  bus response; acknowledges both reads and writes.
- bus_rdata_i  in  DATA_W  bus read data.
- bus_err_o  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, rst_i=1):
  - FSM to IDLE; owner=IF; starve_cnt=0; timeout_cnt=0; discard=0.
  - All outputs 0, including rdata registers.
- FSM states:
  - IDLE: arbitrate when any request is present.
    - Winner is DATA if dm_req_i=1, unless if_req_i=1 and starve_cnt==STARVE_LIMIT, in which case winner is IF.
    - Winner's request fields are latched into bus_* registers; go to ADDR.
  - ADDR: bus_req_o=1 with latched fields. On bus_gnt_i go to WAIT and clear timeout_cnt.
  - WAIT: bus_req_o=0; timeout_cnt increments.
    - On bus_rvalid_i: latch bus_rdata_i; go to RESP.
    - On timeout_cnt==TIMEOUT-1 without rvalid: pulse bus_err_o; go to RESP with rdata=0.
  - RESP: assert owner's valid_o for exactly one cycle (suppressed if discard=1); clear discard; no arbitration this cycle; go to IDLE.
- Minimum latency: request seen in IDLE at cycle 0 with bus_gnt_i already high gives valid_o at cycle 3.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each DATA grant made while if_req_i=1.
  - Clears on each IF grant, and whenever in IDLE with if_req_i=0.
- Stalls are combinational:
  - stall_if_o = if_req_i & ~if_valid_o.
  - stall_mem_o = dm_req_i & ~dm_valid_o.
- Flush (flush_if_i=1):
  - IDLE: no effect; IF is not arbitrated in that cycle.
  - ADDR, owner IF, bus_gnt_i=0: request withdrawn, go to IDLE.
  - ADDR with bus_gnt_i=1, or WAIT/RESP, owner IF: set discard; the response completes on the bus but if_valid_o stays 0.
  - Owner DATA: no effect.
- Simultaneous flush and bus_rvalid_i in WAIT: discard wins.
- Requester protocol: a requester that drops its req before valid violates protocol; the in-flight transaction still completes and the response is dropped silently.
- Mid-operation reset: abandons the transaction immediately; bus_req_o deasserts asynchronously.
- Width rules: addresses and data pass unmodified. Sign/size extension remains in the memory stage.

Decomposition:
- definitions_pkg gains:
  - arb_state_e {IDLE, ADDR, WAIT, RESP}
  - arb_owner_e {OWN_IF, OWN_DM}
  - mem_req_t struct {we, size, addr, wdata}
- One sub-module is natural: arb_timeout_ctr (clear/enable/expire counter, width $clog2(TIMEOUT)).

Test Plan:
- Fetch only, addr 0x0000_0010, gnt immediate, rvalid one cycle after gnt, rdata 0x0000_0013 -> if_valid_o 1 at cycle 3 with if_rdata_o=0x13; stall_if_o high cycles 0-2.
- if_req and dm_req (load 0x100) both asserted in the same cycle -> DATA granted first, dm_valid_o precedes if_valid_o; stall_if_o held throughout.
- dm_req held continuously with back-to-back loads, if_req held, STARVE_LIMIT=4 -> exactly 4 data transactions, then the fetch is granted; starve_cnt returns to 0.
- flush_if_i pulsed in WAIT of a fetch, rvalid two cycles later -> if_valid_o stays 0, FSM reaches IDLE, next fetch completes normally.
- Store (we=1, size=2'b10, addr 0x200, wdata 0xDEADBEEF) -> bus fields match exactly for the ADDR cycle; dm_valid_o pulses after rvalid.
- No rvalid after gnt, TIMEOUT=64 -> bus_err_o pulses 64 cycles after entering WAIT, dm_valid_o=1 with rdata 0; then assert rst_i mid-ADDR -> bus_req_o 0 immediately.
